// File: rtl/instr_fetch.sv
// Program store plus fetch unit: presents two-byte instructions from a writable
// memory over a valid/ready handshake, with run/stop, jumps, halt opcode and wrap.
//
// state   | meaning
// S_IDLE  | not fetching; a presented instruction may still be waiting for accept
// S_FETCH | loading mem[pc], mem[pc+1] whenever the output slot is free
// S_HALT  | halt opcode loaded; only a jump with run=1 resumes fetching
module instr_fetch #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 8,
    parameter int                DEPTH   = 2**ADDR_W,
    parameter logic [DATA_W-1:0] HALT_OP = 8'b1111_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] opcode1,
    output logic [DATA_W-1:0] opcode2,
    output logic [ADDR_W-1:0] rom_address,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] op1_q, op1_d;
    logic [DATA_W-1:0] op2_q, op2_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              load;
    logic              is_halt;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W:0]   pc_sum;
    logic [ADDR_W-1:0] pc_next;

    assign pc_inc  = pc_q + 1'b1;
    assign pc_sum  = {1'b0, pc_q} + (ADDR_W+1)'(2);
    // Modulo DEPTH without a divider; DEPTH need not be a power of two.
    assign pc_next = (pc_sum >= DEPTH_W) ? ADDR_W'(pc_sum - DEPTH_W) : pc_sum[ADDR_W-1:0];
    assign is_halt = (mem_q[pc_q] == HALT_OP);

    // Memory is deliberately outside the reset domain so a program survives reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        addr_d  = addr_q;
        load    = (state_q == S_FETCH) && run && !jump_en && (!valid_q || out_ready);

        case (state_q)
            S_IDLE:  if (run) state_d = S_FETCH;
            S_FETCH: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (load && is_halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT:  if (jump_en && run) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase

        // A jump discards the presented instruction even if it is being accepted.
        if (jump_en) begin
            pc_d    = jump_addr;
            valid_d = 1'b0;
        end else if (load) begin
            op1_d   = mem_q[pc_q];
            op2_d   = (pc_q == LAST_ADDR) ? '0 : mem_q[pc_inc];
            addr_d  = pc_q;
            valid_d = 1'b1;
            if (!is_halt) begin
                pc_d = pc_next;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            addr_q  <= addr_d;
        end
    end

    assign out_valid   = valid_q;
    assign opcode1     = op1_q;
    assign opcode2     = op2_q;
    assign rom_address = addr_q;
    assign halted      = (state_q == S_HALT);

endmodule
